// File: rtl/mpe_kernel_sequencer_if.sv
// Purpose: bundles the layer-controller and MPE-datapath signals of the kernel sequencer.
// Latency: none, wiring only.
// Backpressure: step_valid/step_ready handshake toward the MAC stage.
// Ports: master = sequencer side (drives taps/status); slave = controller/datapath side.
interface mpe_kernel_sequencer_if #(
  parameter int KERNEL_HEIGHT = 4,
  parameter int KERNEL_WIDTH  = 4
);
  localparam int KHW = $clog2(KERNEL_HEIGHT);
  localparam int KWW = $clog2(KERNEL_WIDTH);
  localparam int SW  = $clog2(KERNEL_HEIGHT*KERNEL_WIDTH+1);

  // layer controller side
  logic           start;
  logic           abort;
  logic [KHW:0]   cfg_kernel_height;
  logic [KWW:0]   cfg_kernel_width;
  logic [2:0]     cfg_stride;
  logic           busy;
  logic           done;
  logic           cfg_error;

  // MPE datapath side
  logic           step_valid;
  logic           step_ready;
  logic [KHW-1:0] weight_height;
  logic [KWW-1:0] weight_width;
  logic [2:0]     stride;
  logic           first_step;
  logic           last_step;
  logic [SW-1:0]  step_idx;

  modport master (
    input  start, abort, cfg_kernel_height, cfg_kernel_width, cfg_stride, step_ready,
    output step_valid, weight_height, weight_width, stride, first_step, last_step,
           step_idx, busy, done, cfg_error
  );

  modport slave (
    output start, abort, cfg_kernel_height, cfg_kernel_width, cfg_stride, step_ready,
    input  step_valid, weight_height, weight_width, stride, first_step, last_step,
           step_idx, busy, done, cfg_error
  );
endinterface

// File: rtl/mpe_kernel_sequencer.sv
// Purpose: walks every kernel tap of one conv pass, presenting (row, col, stride) to the MPE mapper.
// Latency: first tap valid the cycle after start; one tap per cycle; done the cycle after the last accept.
// Backpressure: step_ready=0 freezes all tap outputs; only an accept advances the offsets.
// Ports: clock, reset_n (async active-low); bus (master modport) carries start/abort/cfg,
//        the step handshake with tap offsets, and busy/done/cfg_error status.
module mpe_kernel_sequencer #(
  parameter int KERNEL_HEIGHT = 4,
  parameter int KERNEL_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mpe_kernel_sequencer_if.master bus
);
  localparam int KHW = $clog2(KERNEL_HEIGHT);
  localparam int KWW = $clog2(KERNEL_WIDTH);
  localparam int SW  = $clog2(KERNEL_HEIGHT*KERNEL_WIDTH+1);

  localparam logic [KHW:0] KH_MAX = (KHW+1)'(KERNEL_HEIGHT);
  localparam logic [KWW:0] KW_MAX = (KWW+1)'(KERNEL_WIDTH);
  localparam logic [KHW:0] KH_ONE = (KHW+1)'(1);
  localparam logic [KWW:0] KW_ONE = (KWW+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [KHW:0]   kh_q, kh_d;
  logic [KWW:0]   kw_q, kw_d;
  logic [2:0]     stride_q, stride_d;
  logic [KHW-1:0] wh_q, wh_d;
  logic [KWW-1:0] ww_q, ww_d;
  logic [SW-1:0]  idx_q, idx_d;
  logic           cfg_err_q, cfg_err_d;

  logic cfg_ok;
  logic row_end;
  logic last_tap;
  logic accept;

  assign cfg_ok = (bus.cfg_kernel_height != '0) && (bus.cfg_kernel_height <= KH_MAX) &&
                  (bus.cfg_kernel_width  != '0) && (bus.cfg_kernel_width  <= KW_MAX);

  // Tap position decoded purely from registered offsets and latched size.
  assign row_end  = ({1'b0, ww_q} == (kw_q - KW_ONE));
  assign last_tap = row_end && ({1'b0, wh_q} == (kh_q - KH_ONE));
  assign accept   = (state_q == RUN) && bus.step_ready;

  always_comb begin
    state_d   = state_q;
    kh_d      = kh_q;
    kw_d      = kw_q;
    stride_d  = stride_q;
    wh_d      = wh_q;
    ww_d      = ww_q;
    idx_d     = idx_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            kh_d     = bus.cfg_kernel_height;
            kw_d     = bus.cfg_kernel_width;
            stride_d = (bus.cfg_stride == 3'd0) ? 3'd1 : bus.cfg_stride;
            wh_d     = '0;
            ww_d     = '0;
            idx_d    = '0;
            state_d  = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // abort wins over a same-cycle accept: pass is dropped, no done.
        if (bus.abort) begin
          wh_d    = '0;
          ww_d    = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          if (last_tap) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + SW'(1);
            if (row_end) begin
              ww_d = '0;
              wh_d = wh_q + KHW'(1);
            end else begin
              ww_d = ww_q + KWW'(1);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      kh_q      <= KH_ONE;
      kw_q      <= KW_ONE;
      stride_q  <= 3'd1;
      wh_q      <= '0;
      ww_q      <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kh_q      <= kh_d;
      kw_q      <= kw_d;
      stride_q  <= stride_d;
      wh_q      <= wh_d;
      ww_q      <= ww_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.step_valid    = (state_q == RUN);
  assign bus.weight_height = wh_q;
  assign bus.weight_width  = ww_q;
  assign bus.stride        = stride_q;
  assign bus.first_step    = (state_q == RUN) && (idx_q == '0);
  assign bus.last_step     = (state_q == RUN) && last_tap;
  assign bus.step_idx      = idx_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.cfg_error     = cfg_err_q;
endmodule

// File: tb/tb_mpe_kernel_sequencer.sv
// Purpose: directed self-checking bench for mpe_kernel_sequencer.
// Latency: samples 1 time unit after each rising edge; inputs change at the same point.
// Backpressure: step_ready driven from directed patterns.
module tb_mpe_kernel_sequencer;
  localparam int KH = 4;
  localparam int KW = 4;

  logic clock;
  logic reset_n;
  int   n_pass;
  int   n_total;

  mpe_kernel_sequencer_if #(.KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KW)) bus ();

  mpe_kernel_sequencer #(.KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_reset_vals(input string tag);
    chk({tag, ".valid"},  32'(bus.step_valid), 0);
    chk({tag, ".wh"},     32'(bus.weight_height), 0);
    chk({tag, ".ww"},     32'(bus.weight_width), 0);
    chk({tag, ".stride"}, 32'(bus.stride), 1);
    chk({tag, ".first"},  32'(bus.first_step), 0);
    chk({tag, ".last"},   32'(bus.last_step), 0);
    chk({tag, ".idx"},    32'(bus.step_idx), 0);
    chk({tag, ".busy"},   32'(bus.busy), 0);
    chk({tag, ".done"},   32'(bus.done), 0);
    chk({tag, ".cfgerr"}, 32'(bus.cfg_error), 0);
  endtask

  task automatic chk_tap(input string tag, input int k, input int w, input int n, input int s);
    chk({tag, ".valid"},  32'(bus.step_valid), 1);
    chk({tag, ".wh"},     32'(bus.weight_height), k / w);
    chk({tag, ".ww"},     32'(bus.weight_width), k % w);
    chk({tag, ".idx"},    32'(bus.step_idx), k);
    chk({tag, ".stride"}, 32'(bus.stride), s);
    chk({tag, ".first"},  32'(bus.first_step), (k == 0) ? 1 : 0);
    chk({tag, ".last"},   32'(bus.last_step), (k == n - 1) ? 1 : 0);
    chk({tag, ".done"},   32'(bus.done), 0);
  endtask

  task automatic do_start(input int h, input int w, input int s);
    bus.cfg_kernel_height = 3'(h);
    bus.cfg_kernel_width  = 3'(w);
    bus.cfg_stride        = 3'(s);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Full pass with step_ready held high: one tap per cycle, then one done cycle.
  task automatic run_pass(input string tag, input int h, input int w, input int s);
    int es;
    es = (s == 0) ? 1 : s;
    bus.step_ready = 1'b1;
    do_start(h, w, s);
    for (int k = 0; k < h * w; k++) begin
      chk_tap($sformatf("%s.tap%0d", tag, k), k, w, h * w, es);
      tick();
    end
    chk({tag, ".done"},       32'(bus.done), 1);
    chk({tag, ".done_valid"}, 32'(bus.step_valid), 0);
    chk({tag, ".done_busy"},  32'(bus.busy), 1);
    tick();
    chk({tag, ".post_done"},  32'(bus.done), 0);
    chk({tag, ".post_busy"},  32'(bus.busy), 0);
  endtask

  initial begin
    int k;
    int cyc;
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_kernel_height = '0;
    bus.cfg_kernel_width  = '0;
    bus.cfg_stride        = '0;
    bus.step_ready        = 1'b0;
    #12;
    chk_idle_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // 3x3, stride 2, ready tied high
    run_pass("p33s2", 3, 3, 2);

    // 3x3 with ready pattern 1,0,0: taps hold while not ready
    do_start(3, 3, 2);
    k   = 0;
    cyc = 0;
    while (k < 9 && cyc < 60) begin
      bus.step_ready = (cyc % 3 == 0);
      chk_tap($sformatf("bp.c%0d", cyc), k, 3, 9, 2);
      tick();
      if (cyc % 3 == 0) k++;
      cyc++;
    end
    bus.step_ready = 1'b0;
    chk("bp.accepts", 32'(k), 9);
    chk("bp.done",    32'(bus.done), 1);
    tick();
    chk("bp.idle",    32'(bus.busy), 0);

    // illegal height 0
    do_start(0, 3, 1);
    chk("err_h.cfgerr", 32'(bus.cfg_error), 1);
    chk("err_h.busy",   32'(bus.busy), 0);
    chk("err_h.valid",  32'(bus.step_valid), 0);
    tick();
    chk("err_h.pulse",  32'(bus.cfg_error), 0);
    chk("err_h.valid2", 32'(bus.step_valid), 0);

    // illegal width KW+1
    do_start(3, KW + 1, 1);
    chk("err_w.cfgerr", 32'(bus.cfg_error), 1);
    chk("err_w.busy",   32'(bus.busy), 0);
    chk("err_w.valid",  32'(bus.step_valid), 0);
    tick();
    chk("err_w.pulse",  32'(bus.cfg_error), 0);

    // 1x1 with stride 0 -> stride 1, single first+last tap
    run_pass("p11s0", 1, 1, 0);

    // max size 4x4, stride 7
    run_pass("p44s7", KH, KW, 7);

    // abort at step_idx 4 with ready high
    bus.step_ready = 1'b1;
    do_start(3, 3, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("ab.idx_before", 32'(bus.step_idx), 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab.valid", 32'(bus.step_valid), 0);
    chk("ab.wh",    32'(bus.weight_height), 0);
    chk("ab.ww",    32'(bus.weight_width), 0);
    chk("ab.idx",   32'(bus.step_idx), 0);
    chk("ab.busy",  32'(bus.busy), 0);
    chk("ab.done",  32'(bus.done), 0);
    tick();
    chk("ab.done2", 32'(bus.done), 0);
    run_pass("ab.rerun", 3, 3, 1);

    // async reset at step_idx 5
    bus.step_ready = 1'b1;
    do_start(3, 3, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("rst.idx_before", 32'(bus.step_idx), 5);
    #1;
    reset_n = 1'b0;
    #1;
    chk_idle_reset_vals("rst.async");
    reset_n = 1'b1;
    tick();
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    do_start(2, 3, 3);
    chk_tap("rst.restart", 0, 3, 6, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mpe_kernel_sequencer.md
# mpe_kernel_sequencer

Control FSM that walks one convolution pass over every kernel tap and drives the tap offset and stride inputs of the MPE input-to-output window mapper. On each tap it presents the row offset, the column offset and the latched stride to the MPE datapath. A valid/ready handshake with the downstream MAC/accumulator stage sets the pace, and first/last flags mark accumulator clear and commit. Sits between the layer controller (start/config/done) and the MPE array.

## Interface
- KERNEL_HEIGHT, default `KERNEL_HEIGHT` from sys_defs (≥2), maximum kernel rows.
- KERNEL_WIDTH, default `KERNEL_WIDTH` from sys_defs (≥2), maximum kernel columns.
- KHW = $clog2(KERNEL_HEIGHT); KWW = $clog2(KERNEL_WIDTH); SW = $clog2(KERNEL_HEIGHT*KERNEL_WIDTH+1) (localparams).
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  start pulse; sampled only in IDLE.
- abort  in  1  cancel current pass; ignored outside RUN.
- cfg_kernel_height  in  KHW+1  kernel rows used this pass, legal range 1..KERNEL_HEIGHT.
- cfg_kernel_width  in  KWW+1  kernel columns used this pass, legal range 1..KERNEL_WIDTH.
- cfg_stride  in  3  convolution stride; 0 is treated as 1.
- step_valid  out  1  current tap offset is valid.
- step_ready  in  1  MPE/MAC stage accepts the current tap.
- weight_height  out  KHW  tap row offset to the mapper.
- weight_width  out  KWW  tap column offset to the mapper.
- stride  out  3  latched stride to the mapper.
- first_step  out  1  current tap is tap 0; accumulator clears.
- last_step  out  1  current tap is the final tap; accumulator commits.
- step_idx  out  SW  linear tap index, row-major.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last tap is accepted.
- cfg_error  out  1  one-cycle pulse when start is rejected because of an illegal config.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, config legal: latch kh, kw and stride (0 becomes 1); clear offsets and step_idx; go to RUN.
- IDLE, start=1, config illegal (kh or kw equal to 0, or above its max): pulse cfg_error and stay in IDLE. Nothing is latched.
- RUN: step_valid=1.
  - first_step = (step_idx==0).
  - last_step = (weight_height==kh-1 && weight_width==kw-1).
- RUN, accept (step_valid && step_ready):
  - Not last tap: step_idx+1. weight_width+1; if weight_width==kw-1 it wraps to 0 and weight_height increments.
  - Last tap: go to DONE. Offsets and step_idx hold.
- RUN, step_ready=0: all step outputs hold stable. Offsets never change without an accept.
- RUN, abort=1: go to IDLE. abort has priority over a same-cycle accept. The accept still counts for the consumer, but done does not pulse and offsets/step_idx clear to 0.
- DONE: done=1 for exactly one cycle, step_valid=0, then IDLE. start is ignored in DONE.
- start is ignored in RUN and DONE; latched config cannot change mid-pass.
- kh=kw=1: a single tap with first_step and last_step both high.
- Tap count per pass = kh*kw. step_idx never exceeds kh*kw-1.

## Timing
- Reset (async, immediate) values: state IDLE; step_valid 0; weight_height 0; weight_width 0; stride 3'd1; first_step 0; last_step 0; step_idx 0; busy 0; done 0; cfg_error 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from step_ready to step_valid or to the offsets.
- start at edge t: step_valid=1 with tap (0,0) from cycle t+1.
- Back-to-back accepts give one tap per cycle. A full pass with step_ready tied high takes kh*kw RUN cycles, plus 1 DONE cycle, plus the return to IDLE.
- done is high in the cycle after the last accept. A new start is accepted one cycle after done, at the earliest.
- cfg_error is high in the cycle after the rejected start.
- reset_n deassertion mid-pass: the sequencer restarts in IDLE. No done pulse.

## Test plan
- kh=3, kw=3, stride=2, step_ready=1 -> 9 consecutive valid cycles with (h,w) = (0,0)(0,1)(0,2)(1,0)…(2,2), step_idx 0..8, stride=2 throughout, first_step on cycle 1 only, last_step on cycle 9 only, done on cycle 10.
- Same config, step_ready toggling 1,0,0,1,… -> offsets and step_idx stable while ready=0; exactly 9 accepts; done after the 9th accept.
- cfg_kernel_height=0, and separately cfg_kernel_width=KERNEL_WIDTH+1 -> cfg_error pulses 1 cycle, busy stays 0, no step_valid.
- kh=1, kw=1, cfg_stride=0 -> single step with first_step=last_step=1, stride=1, done the next cycle.
- abort asserted at step_idx=4 with step_ready=1 -> IDLE next cycle, step_valid 0, offsets 0, no done. A following start runs a full, clean pass.
- reset_n pulsed low at step_idx=5 -> all outputs at reset values immediately; start after release begins again at (0,0).
